// File: rtl/img_grad_pkg.sv
// Shared definitions for the streaming gradient engine: mode codes, FSM states,
// and the helper that turns a signed gx/gy pair into the selected output format.
package img_grad_pkg;

    localparam logic [1:0] MODE_SIGNED = 2'b00;
    localparam logic [1:0] MODE_ABS    = 2'b01;
    localparam logic [1:0] MODE_L1     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_EOL,
        ST_FIN
    } state_t;

    // Works on 32-bit fields so one function serves every GRAD_W; callers
    // truncate each half back to their field width. Returns {hi, lo}.
    function automatic logic [63:0] grad_pack(input logic [1:0]         mode,
                                              input logic signed [31:0] gx,
                                              input logic signed [31:0] gy,
                                              input logic [31:0]        sat_max);
        logic [31:0] ax;
        logic [31:0] ay;
        logic [31:0] l1;
        ax = gx[31] ? -gx : gx;
        ay = gy[31] ? -gy : gy;
        l1 = ax + ay;
        if (l1 > sat_max) begin
            l1 = sat_max;
        end
        case (mode)
            MODE_ABS: grad_pack = {ax, ay};
            MODE_L1:  grad_pack = {32'd0, l1};
            default:  grad_pack = {gx, gy};
        endcase
    endfunction

endpackage

// File: rtl/img_grad_stream_line_buf.sv
// One-row pixel store. Read is combinational so the old pixel of a column is
// seen in the same cycle the new pixel of that column is written.
module line_buf #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/img_grad_stream.sv
// Streaming forward-difference gradient engine: raster reads from the image
// SRAM, one line buffer, one packed {gx,gy} write per pixel of rows 0..IMG_H-2.
module img_grad_stream
    import img_grad_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16,
    parameter int GRAD_W = PIX_W + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                img_rd,
    output logic [ADDR_W-1:0]   img_addr,
    input  logic [PIX_W-1:0]    img_di,
    output logic                grad_wr,
    output logic [ADDR_W-1:0]   grad_addr,
    output logic [2*GRAD_W-1:0] grad_do
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_END   = YW'(IMG_H);
    localparam logic [31:0]   SAT_MAX = 32'((1 << (GRAD_W - 1)) - 1);

    state_t state, state_nxt;

    logic [XW-1:0]     x, dx;
    logic [YW-1:0]     y, dy;
    logic [ADDR_W-1:0] rd_addr, wr_cnt;
    logic [1:0]        mode_q;
    logic              dv, tail, prod, drained;
    logic [PIX_W-1:0]  cur_prev, up_prev, lb_rd;

    logic signed [GRAD_W-1:0] up_e, up_prev_e, cur_prev_e, gx, gy;
    logic [63:0]              packed_w;
    logic [2*GRAD_W-1:0]      word;

    // Pipeline empty: no pixel in flight, no last-column write pending or visible.
    assign drained = !dv && !tail && !grad_wr;

    always_comb begin
        state_nxt = state;
        img_rd    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                img_rd = 1'b1;
                if (x == X_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                img_rd = 1'b1;
                if (x == X_LAST) state_nxt = ST_EOL;
            end
            ST_EOL: state_nxt = (y == Y_END) ? ST_FIN : ST_RUN;
            ST_FIN: begin
                if (drained) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            rd_addr <= '0;
            mode_q  <= MODE_SIGNED;
        end else if (state == ST_IDLE && start) begin
            x       <= '0;
            y       <= '0;
            rd_addr <= '0;
            mode_q  <= mode;
        end else if (img_rd) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            if (x == X_LAST) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign img_addr = rd_addr;

    line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_line_buf (
        .clk     (clk),
        .wr      (dv),
        .wr_addr (dx),
        .wr_data (img_di),
        .rd_addr (dx),
        .rd_data (lb_rd)
    );

    // Arrival of p(dx,dy) completes output pixel (dx-1,dy-1); the last column
    // of each row is emitted one cycle later, in the slot left by the EOL gap.
    assign prod       = dv && (dx != '0) && (dy != '0);
    assign up_e       = $signed(GRAD_W'(lb_rd));
    assign up_prev_e  = $signed(GRAD_W'(up_prev));
    assign cur_prev_e = $signed(GRAD_W'(cur_prev));
    assign gx         = tail ? '0 : (up_e - up_prev_e);
    assign gy         = cur_prev_e - up_prev_e;
    assign packed_w   = grad_pack(mode_q, 32'(gx), 32'(gy), SAT_MAX);
    assign word       = {GRAD_W'(packed_w[63:32]), GRAD_W'(packed_w[31:0])};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv        <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            tail      <= 1'b0;
            cur_prev  <= '0;
            up_prev   <= '0;
            grad_wr   <= 1'b0;
            grad_addr <= '0;
            grad_do   <= '0;
            wr_cnt    <= '0;
        end else begin
            dv      <= img_rd;
            dx      <= x;
            dy      <= y;
            tail    <= dv && (dx == X_LAST) && (dy != '0);
            grad_wr <= prod || tail;
            if (dv) begin
                cur_prev <= img_di;
                up_prev  <= lb_rd;
            end
            if (state == ST_IDLE && start) begin
                wr_cnt <= '0;
            end else if (prod || tail) begin
                grad_addr <= wr_cnt;
                grad_do   <= word;
                wr_cnt    <= wr_cnt + ADDR_W'(1);
            end
        end
    end

endmodule
